// File: rtl/ram8.sv
// Eight-word register file: load is demuxed by address to one word register,
// and the read port is an 8-way combinational mux with no write-through bypass.
module ram8 #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_load,
  input  logic [2:0]       i_address,
  output logic [WIDTH-1:0] o_out
);

  logic [7:0]       w_load;
  logic [WIDTH-1:0] r_word [8];

  // 1-to-8 demux of load into per-word write enables
  always_comb begin
    w_load = 8'b0000_0000;
    if (i_load) begin
      case (i_address)
        3'd0:    w_load = 8'b0000_0001;
        3'd1:    w_load = 8'b0000_0010;
        3'd2:    w_load = 8'b0000_0100;
        3'd3:    w_load = 8'b0000_1000;
        3'd4:    w_load = 8'b0001_0000;
        3'd5:    w_load = 8'b0010_0000;
        3'd6:    w_load = 8'b0100_0000;
        3'd7:    w_load = 8'b1000_0000;
        default: w_load = 8'b0000_0000;
      endcase
    end else begin
      w_load = 8'b0000_0000;
    end
  end

  // Word storage; reset wins over any write in the same cycle
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < 8; k++) begin
      if (i_reset) begin
        r_word[k] <= '0;
      end else if (w_load[k]) begin
        r_word[k] <= i_in;
      end else begin
        r_word[k] <= r_word[k];
      end
    end
  end

  // 8-way read mux, combinational from address and current contents
  always_comb begin
    o_out = '0;
    case (i_address)
      3'd0:    o_out = r_word[0];
      3'd1:    o_out = r_word[1];
      3'd2:    o_out = r_word[2];
      3'd3:    o_out = r_word[3];
      3'd4:    o_out = r_word[4];
      3'd5:    o_out = r_word[5];
      3'd6:    o_out = r_word[6];
      3'd7:    o_out = r_word[7];
      default: o_out = '0;
    endcase
  end

endmodule

// File: tb/tb_ram8.sv
// Self-checking bench for ram8: array model updated on each rising edge,
// compared on every falling edge, plus hand-computed literal read checks.
module tb_ram8;

  logic        clk;
  logic        i_reset;
  logic [15:0] i_in;
  logic        i_load;
  logic [2:0]  i_address;
  logic [15:0] o_out;

  ram8 #(.WIDTH(16)) dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_in      (i_in),
    .i_load    (i_load),
    .i_address (i_address),
    .o_out     (o_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] m [8];
  logic        m_valid = 1'b0;

  logic        lit_en = 1'b0;
  logic [15:0] lit_exp = 16'h0000;
  string       lit_name = "";

  int n_cmp = 0;
  int n_err = 0;

  // Reference memory: reset clears everything, otherwise load writes one word
  always @(posedge clk) begin
    if (i_reset) begin
      for (int k = 0; k < 8; k++) m[k] = 16'h0000;
      m_valid = 1'b1;
    end else if (i_load && m_valid) begin
      m[i_address] = i_in;
    end
  end

  // Single compare process: model every cycle, literals when requested
  always @(negedge clk) begin
    if (m_valid) begin
      n_cmp++;
      if (o_out !== m[i_address]) begin
        n_err++;
        $display("FAIL model_cmp addr=%0d: got %h expected %h at %0t", i_address, o_out, m[i_address], $time);
      end
      if (lit_en) begin
        n_cmp++;
        if (o_out !== lit_exp) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", lit_name, o_out, lit_exp);
        end
        n_cmp++;
        if (m[i_address] !== lit_exp) begin
          n_err++;
          $display("FAIL %s(model): got %h expected %h", lit_name, m[i_address], lit_exp);
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic l, input logic [2:0] a, input logic [15:0] d);
    i_reset = r; i_load = l; i_address = a; i_in = d;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
    i_reset = 1'b0; i_load = 1'b0; i_address = a; i_in = 16'h0000;
    lit_exp = exp; lit_name = name; lit_en = 1'b1;
    @(posedge clk); #1;
    lit_en = 1'b0;
  endtask

  logic [15:0] hold_exp [8];

  initial begin
    i_reset = 1'b0; i_load = 1'b0; i_address = 3'd0; i_in = 16'h0000;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset then sweep
    cyc(1'b1, 1'b0, 3'd0, 16'h0000);
    for (int k = 0; k < 8; k++) rd(3'(k), 16'h0000, "reset_sweep");

    // Fill and readback
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, 3'(k), 16'(k * 32'h1111));
    for (int k = 0; k < 8; k++) rd(3'(k), 16'(k * 32'h1111), "fill_readback");

    // Read during write: old value before the edge, new value after
    cyc(1'b0, 1'b1, 3'd3, 16'hAAAA);
    i_reset = 1'b0; i_load = 1'b1; i_address = 3'd3; i_in = 16'h5555;
    lit_exp = 16'hAAAA; lit_name = "rdw_old"; lit_en = 1'b1;
    @(posedge clk); #1;
    lit_en = 1'b0;
    rd(3'd3, 16'h5555, "rdw_new");
    rd(3'd2, 16'h2222, "rdw_neighbor2");
    rd(3'd4, 16'h4444, "rdw_neighbor4");

    // Load low hold on address 5
    for (int n = 0; n < 3; n++) cyc(1'b0, 1'b0, 3'd5, 16'hFFFF);
    hold_exp[0] = 16'h0000; hold_exp[1] = 16'h1111; hold_exp[2] = 16'h2222; hold_exp[3] = 16'h5555;
    hold_exp[4] = 16'h4444; hold_exp[5] = 16'h5555; hold_exp[6] = 16'h6666; hold_exp[7] = 16'h7777;
    for (int k = 0; k < 8; k++) rd(3'(k), hold_exp[k], "load_low_hold");

    // Reset priority over a simultaneous write
    cyc(1'b0, 1'b1, 3'd6, 16'h1234);
    rd(3'd6, 16'h1234, "pre_reset_w6");
    cyc(1'b1, 1'b1, 3'd6, 16'hBEEF);
    for (int k = 0; k < 8; k++) rd(3'(k), 16'h0000, "reset_priority");

    // Reset mid-fill, then resume
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 3'(k), 16'(k * 32'h1111));
    rd(3'd4, 16'h4444, "midfill_w4");
    cyc(1'b1, 1'b0, 3'd0, 16'h0000);
    cyc(1'b0, 1'b1, 3'd7, 16'h8001);
    rd(3'd7, 16'h8001, "resume_w7");
    for (int k = 0; k < 7; k++) rd(3'(k), 16'h0000, "resume_cleared");

    // Bit-exact all-ones
    cyc(1'b0, 1'b1, 3'd0, 16'hFFFF);
    rd(3'd0, 16'hFFFF, "all_ones");
    rd(3'd7, 16'h8001, "all_ones_other");

    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
